// File: rtl/cpu_pkg.sv
// Shared EX-stage types: opcode and branch-condition encodings, flag bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Used by ex_flag_unit and by the decode-stage branch resolver, so the
// encodings here are the single source of truth for both.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LLB    = 4'b1010,
        OP_LHB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_t;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GTE = 3'b100,
        CC_LTE = 3'b101,
        CC_OV  = 3'b110,
        CC_UN  = 3'b111
    } cond_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    // Arithmetic ops write all three flags.
    function automatic logic sets_all(opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Logic/shift ops write Z only; N and V keep their previous value.
    function automatic logic sets_z(opcode_t op);
        return sets_all(op) || (op == OP_XOR) || (op == OP_SLL) ||
               (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: (flags, 3-bit condition code) -> taken.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   flags_i   - Z/V/N flag bundle to test
//   br_cond_i - condition code of the branch being resolved
//   taken_o   - 1 when the condition holds
module branch_cond_eval
    import cpu_pkg::*;
(
    input  flags_t     flags_i,
    input  logic [2:0] br_cond_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b1;
        case (cond_t'(br_cond_i))
            CC_NE:   taken_o = ~flags_i.z;
            CC_EQ:   taken_o = flags_i.z;
            CC_GT:   taken_o = ~flags_i.z & ~flags_i.n;
            CC_LT:   taken_o = flags_i.n;
            CC_GTE:  taken_o = flags_i.z | (~flags_i.z & ~flags_i.n);
            CC_LTE:  taken_o = flags_i.n | flags_i.z;
            CC_OV:   taken_o = flags_i.v;
            CC_UN:   taken_o = 1'b1;
            default: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_flag_unit.sv
// EX-stage flag unit: captures ALU result/overflow into Z/V/N, resolves branch condition, HLT freeze.
// Latency: flags and halted update one clk edge after the EX instruction; branch_taken is combinational.
// Backpressure: stall or flush blocks the update (flush wins); HALTED blocks all updates until rst.
//
// Ports:
//   clk, rst                 - clock (rising edge), asynchronous active-high reset
//   ex_valid, stall, flush   - EX-slot qualifiers
//   opcode, alu_result, alu_ovfl - EX instruction and adder/ALU outputs
//   br_cond                  - condition code for the branch resolver
//   z_flag, v_flag, n_flag   - registered architectural flags
//   branch_taken             - condition result (next or registered flags, per BYPASS)
//   halted                   - unit is frozen after HLT
module ex_flag_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovfl,
    input  logic [2:0]        br_cond,
    output logic              z_flag,
    output logic              v_flag,
    output logic              n_flag,
    output logic              branch_taken,
    output logic              halted
);

    state_t  state_q, state_d;
    flags_t  flags_q, flags_d;
    flags_t  br_flags;
    opcode_t op;
    logic    upd;

    assign op = opcode_t'(opcode);

    // flush dominates stall and valid; HALTED suppresses everything.
    assign upd = ex_valid & ~stall & ~flush & (state_q == ST_RUN);

    always_comb begin
        flags_d = flags_q;
        state_d = state_q;
        if (upd) begin
            if (sets_z(op)) begin
                flags_d.z = (alu_result == '0);
            end
            if (sets_all(op)) begin
                flags_d.n = alu_result[DATA_W-1];
                flags_d.v = alu_ovfl;
            end
            if (op == OP_HLT) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // With bypass, a branch resolving in the same cycle as a flag-setting
    // instruction sees that instruction's result without a bubble.
    assign br_flags = BYPASS ? flags_d : flags_q;

    branch_cond_eval u_cond (
        .flags_i   (br_flags),
        .br_cond_i (br_cond),
        .taken_o   (branch_taken)
    );

    assign z_flag = flags_q.z;
    assign v_flag = flags_q.v;
    assign n_flag = flags_q.n;
    assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ex_flag_unit.sv
module tb_ex_flag_unit;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst;
    logic        ex_valid, stall, flush, alu_ovfl;
    logic [3:0]  opcode;
    logic [15:0] alu_result;
    logic [2:0]  br_cond;

    logic z_b, v_b, n_b, tk_b, h_b;   // BYPASS=1 instance
    logic z_r, v_r, n_r, tk_r, h_r;   // BYPASS=0 instance

    int vecs = 0;
    int errs = 0;

    always #5 if (clk_run) clk = ~clk;

    ex_flag_unit #(.DATA_W(16), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .flush(flush),
        .opcode(opcode), .alu_result(alu_result), .alu_ovfl(alu_ovfl), .br_cond(br_cond),
        .z_flag(z_b), .v_flag(v_b), .n_flag(n_b), .branch_taken(tk_b), .halted(h_b)
    );

    ex_flag_unit #(.DATA_W(16), .BYPASS(1'b0)) dut_reg (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .flush(flush),
        .opcode(opcode), .alu_result(alu_result), .alu_ovfl(alu_ovfl), .br_cond(br_cond),
        .z_flag(z_r), .v_flag(v_r), .n_flag(n_r), .branch_taken(tk_r), .halted(h_r)
    );

    task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] op,
                         input logic [15:0] res, input logic ov, input logic [2:0] cc);
        ex_valid   = v;
        stall      = st;
        flush      = fl;
        opcode     = op;
        alu_result = res;
        alu_ovfl   = ov;
        br_cond    = cc;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 3'b000);
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        vecs++; if ({z_b, v_b, n_b, h_b} !== 4'b0000) begin errs++; $display("FAIL reset_byp zvnh=%b exp=0000", {z_b, v_b, n_b, h_b}); end
        vecs++; if ({z_r, v_r, n_r, h_r} !== 4'b0000) begin errs++; $display("FAIL reset_reg zvnh=%b exp=0000", {z_r, v_r, n_r, h_r}); end
        vecs++; if ({tk_b, tk_r} !== 2'b11) begin errs++; $display("FAIL reset_ne taken=%b exp=11", {tk_b, tk_r}); end
        br_cond = 3'b001;
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b00) begin errs++; $display("FAIL reset_eq taken=%b exp=00", {tk_b, tk_r}); end
        rst = 1'b0;
        #1 clk_run = 1'b1;
    endtask

    task automatic test_add_ovfl;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 16'h8000, 1'b1, 3'b110);
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b10) begin errs++; $display("FAIL add_ov_pre taken(byp,reg)=%b exp=10", {tk_b, tk_r}); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b110);
        vecs++; if ({z_b, v_b, n_b} !== 3'b011) begin errs++; $display("FAIL add_ov_byp zvn=%b exp=011", {z_b, v_b, n_b}); end
        vecs++; if ({z_r, v_r, n_r} !== 3'b011) begin errs++; $display("FAIL add_ov_reg zvn=%b exp=011", {z_r, v_r, n_r}); end
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b11) begin errs++; $display("FAIL add_ov_cc110 taken=%b exp=11", {tk_b, tk_r}); end
        br_cond = 3'b011;
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b11) begin errs++; $display("FAIL add_ov_cc011 taken=%b exp=11", {tk_b, tk_r}); end
    endtask

    task automatic test_xor_zero;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0010, 16'h0000, 1'b0, 3'b001);
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b10) begin errs++; $display("FAIL xor_pre_eq taken=%b exp=10", {tk_b, tk_r}); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b101);
        vecs++; if ({z_b, v_b, n_b} !== 3'b111) begin errs++; $display("FAIL xor_byp zvn=%b exp=111", {z_b, v_b, n_b}); end
        vecs++; if ({z_r, v_r, n_r} !== 3'b111) begin errs++; $display("FAIL xor_reg zvn=%b exp=111", {z_r, v_r, n_r}); end
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b11) begin errs++; $display("FAIL xor_cc101 taken=%b exp=11", {tk_b, tk_r}); end
    endtask

    task automatic test_stall_flush;
        // SUB result 0 while stalled: flags must hold at 111
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 4'b0001, 16'h0000, 1'b0, 3'b110);
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b11) begin errs++; $display("FAIL stall_pre_ov taken=%b exp=11", {tk_b, tk_r}); end
        @(posedge clk); #1;
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b111111) begin errs++; $display("FAIL stall_hold zvn=%b exp=111111", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        // drop stall
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b000);
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b100100) begin errs++; $display("FAIL unstall_sub zvn=%b exp=100100", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        // flushed ADD that would set Z=0 V=1 N=1
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 16'h8000, 1'b1, 3'b000);
        @(posedge clk); #1;
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b100100) begin errs++; $display("FAIL flush_add zvn=%b exp=100100", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        // HLT under stall+flush, stall alone, flush alone: never halts
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 4'b1111, 16'h0000, 1'b0, 3'b000);
        @(posedge clk); #1;
        vecs++; if ({h_b, h_r} !== 2'b00) begin errs++; $display("FAIL hlt_stall_flush halted=%b exp=00", {h_b, h_r}); end
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk); #1;
        vecs++; if ({h_b, h_r} !== 2'b00) begin errs++; $display("FAIL hlt_stall halted=%b exp=00", {h_b, h_r}); end
        @(negedge clk);
        stall = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b000);
        vecs++; if ({h_b, h_r} !== 2'b00) begin errs++; $display("FAIL hlt_flush halted=%b exp=00", {h_b, h_r}); end
    endtask

    task automatic test_bypass;
        // ADD 0x0001 -> Z=0 N=0 V=0
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0001, 1'b0, 3'b001);
        @(posedge clk); #1;
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b000000) begin errs++; $display("FAIL add_one zvn=%b exp=000000", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        // SUB result 0 with EQ in the same cycle
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000, 1'b0, 3'b001);
        #1;
        vecs++; if (tk_b !== 1'b1) begin errs++; $display("FAIL bypass_eq_byp taken=%b exp=1", tk_b); end
        vecs++; if (tk_r !== 1'b0) begin errs++; $display("FAIL bypass_eq_reg taken=%b exp=0", tk_r); end
        @(posedge clk); #1;
        vecs++; if ({tk_b, tk_r, z_r} !== 3'b111) begin errs++; $display("FAIL bypass_eq_post taken,z=%b exp=111", {tk_b, tk_r, z_r}); end
        // LW with nonzero result: no flag change
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b1000, 16'h0005, 1'b1, 3'b001);
        @(posedge clk); #1;
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b100100) begin errs++; $display("FAIL lw_noflag zvn=%b exp=100100", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        // SLL 0x8000: Z=0, N held at 0 despite MSB
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0100, 16'h8000, 1'b1, 3'b011);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b011);
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b000000) begin errs++; $display("FAIL sll_zonly zvn=%b exp=000000", {z_b, v_b, n_b, z_r, v_r, n_r}); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000, 1'b0, 3'b010);
        @(posedge clk); #1;
        vecs++; if ({z_r, v_r, n_r} !== 3'b100) begin errs++; $display("FAIL b2b_first zvn=%b exp=100", {z_r, v_r, n_r}); end
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 16'hFFFF, 1'b0, 3'b010);
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b00) begin errs++; $display("FAIL b2b_gt taken=%b exp=00", {tk_b, tk_r}); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b100);
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b001001) begin errs++; $display("FAIL b2b_second zvn=%b exp=001001", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b00) begin errs++; $display("FAIL b2b_gte taken=%b exp=00", {tk_b, tk_r}); end
    endtask

    task automatic test_hlt;
        // preload Z=0 V=1 N=1
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 16'h8000, 1'b1, 3'b000);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 16'h0000, 1'b0, 3'b000);
        #1;
        vecs++; if ({h_b, h_r} !== 2'b00) begin errs++; $display("FAIL hlt_pre halted=%b exp=00", {h_b, h_r}); end
        @(posedge clk); #1;
        vecs++; if ({h_b, h_r} !== 2'b11) begin errs++; $display("FAIL hlt_post halted=%b exp=11", {h_b, h_r}); end
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b011011) begin errs++; $display("FAIL hlt_flags zvn=%b exp=011011", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        // ADD result 0 while halted
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b001);
        #1;
        vecs++; if ({tk_b, tk_r} !== 2'b00) begin errs++; $display("FAIL halted_eq taken=%b exp=00", {tk_b, tk_r}); end
        @(posedge clk); #1;
        vecs++; if ({z_b, v_b, n_b, z_r, v_r, n_r} !== 6'b011011) begin errs++; $display("FAIL halted_add zvn=%b exp=011011", {z_b, v_b, n_b, z_r, v_r, n_r}); end
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b000);
        // asynchronous reset between edges
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vecs++; if ({z_b, v_b, n_b, h_b, z_r, v_r, n_r, h_r} !== 8'h00) begin errs++; $display("FAIL async_rst zvnh=%b exp=00000000", {z_b, v_b, n_b, h_b, z_r, v_r, n_r, h_r}); end
        #1 rst = 1'b0;
        // back in RUN: ADD result 0 sets Z
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 3'b000);
        vecs++; if ({z_b, v_b, n_b, h_b, z_r, v_r, n_r, h_r} !== 8'b10001000) begin errs++; $display("FAIL run_after_rst zvnh=%b exp=10001000", {z_b, v_b, n_b, h_b, z_r, v_r, n_r, h_r}); end
    endtask

    initial begin
        test_reset();
        test_add_ovfl();
        test_xor_zero();
        test_stall_flush();
        test_bypass();
        test_back_to_back();
        test_hlt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
